div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for DIV.W/MOD.W/DIV.WU/MOD.WU (alu_op[18:15]) in Execute.
//  Accepts one request, runs a radix-2 restoring divide, sign-fixes and holds the result until taken.
//  Execute stalls (E ready_go low) while busy; flush from branch/exception aborts it.
// PARAMETERS
//  WID   32  operand/result width in bits; CALC runs WID cycles
// PORTS
//  clk        in   1    clock; single clock domain
//  rstn       in   1    reset, asynchronous, active-low
//  req_valid  in   1    Execute presents a divide op
//  req_op     in   4    one-hot {mod_wu,div_wu,mod_w,div_w} = alu_op[18:15]
//  src1       in   WID  dividend (alu_src1)
//  src2       in   WID  divisor (alu_src2)
//  req_ready  out  1    request accepted this cycle when req_valid&&req_ready
//  flush      in   1    synchronous abort of any in-flight op
//  res_valid  out  1    result available
//  res_ready  in   1    Execute consumes result (E ready_go && M allowin)
//  result     out  WID  quotient or remainder per latched op
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, counter=0, req_ready=0 while low, res_valid=0, result=0, busy=0.
//  States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE: req_ready = !flush. On accept: latch op, src1, src2; go PREP.
//  - PREP (1 cyc): signed ops take |src1|, |src2|; record q_neg=s1^s2, r_neg=s1 (sign bits).
//    Divisor==0 -> load result (quotient=all-ones, remainder=src1 unmodified); go DONE, skip CALC/FIX.
//    Else: rem=0, quo=|dividend|, counter=0; go CALC.
//  - CALC (WID cyc): per cycle shift {rem,quo} left 1; trial=rem-divisor (WID+1 bits);
//    trial>=0 -> rem=trial, quo[0]=1; else quo[0]=0. counter++; leave when counter==WID-1.
//  - FIX (1 cyc): result = div ? (q_neg?-quo:quo) : (r_neg?-rem:rem); unsigned ops: no negation.
//    INT_MIN/-1 (signed) yields quotient 0x8000_0000, remainder 0 with no special case.
//  - DONE: res_valid=1, result stable; res_ready -> IDLE next cycle. No new accept in DONE.
//  Latency (accept edge = cycle 0): res_valid high in cycle WID+3 (35); div-by-zero: cycle 2.
//  Throughput: one op in flight; req_ready low in every state except IDLE.
//  flush: any state -> IDLE next edge; res_valid drops next cycle; flush beats accept and res_ready in same cycle.
//  res_ready held low in DONE: stay DONE indefinitely, result unchanged.
//  res_ready / req_op outside IDLE/DONE ignored; req_op not one-hot at accept: treat as div_w.
//  Async reset mid-operation: immediate IDLE, all outputs to reset values, latched operands discarded.
// STRUCTURE
//  Defines.vh: `DIV_OP_Wid (4), state encodings (`DIV_IDLE..`DIV_DONE, 3 bits),
//  `DIV0_QUO (all-ones); port widths from the existing alu_op macros.
//  Sub-module div_step: combinational one restoring step
//  ({rem,quo},divisor) -> ({rem',quo'}); controller owns FSM, counter, sign fix.
// TESTING
//  1. div_w 100/7 -> res_valid at cycle 35, result=14; mod_w same -> 2.
//  2. mod_w -7 % 2 -> 0xFFFF_FFFF; div_w -7/2 -> 0xFFFF_FFFD (truncate toward zero).
//  3. div_wu 0xFFFF_FFFF/2 -> 0x7FFF_FFFF; div_w 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; mod_w -> 0.
//  4. div_w 5/0 -> cycle 2 result 0xFFFF_FFFF; mod_wu 5/0 -> 5.
//  5. flush in CALC cycle 10 -> IDLE next edge, req_ready=1, no res_valid;
//     new req 9/3 then -> 3.
//  6. res_ready low 5 cycles in DONE -> result held;
//     rstn pulse mid-CALC -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// Shared types for the sequential divide controller: FSM states,
// one-hot operation codes and the op decode helper.
package div_seq_ctrl_pkg;

  localparam int DIV_OP_WID = 4;

  // One-hot {mod_wu, div_wu, mod_w, div_w} as presented by Execute.
  localparam logic [DIV_OP_WID-1:0] OP_DIV_W  = 4'b0001;
  localparam logic [DIV_OP_WID-1:0] OP_MOD_W  = 4'b0010;
  localparam logic [DIV_OP_WID-1:0] OP_DIV_WU = 4'b0100;
  localparam logic [DIV_OP_WID-1:0] OP_MOD_WU = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

  typedef struct packed {
    logic is_div;     // 1: quotient, 0: remainder
    logic is_signed;  // 1: two's-complement operands
  } div_op_t;

  // Malformed (non one-hot) codes fall back to signed divide.
  function automatic div_op_t decode_op(input logic [DIV_OP_WID-1:0] op);
    div_op_t d;
    case (op)
      OP_DIV_W:  d = '{is_div: 1'b1, is_signed: 1'b1};
      OP_MOD_W:  d = '{is_div: 1'b0, is_signed: 1'b1};
      OP_DIV_WU: d = '{is_div: 1'b1, is_signed: 1'b0};
      OP_MOD_WU: d = '{is_div: 1'b0, is_signed: 1'b0};
      default:   d = '{is_div: 1'b1, is_signed: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_step.sv
// One restoring-division step: shift {rem,quo} left by one, try to
// subtract the divisor from the partial remainder, keep the result if
// it did not go negative and shift the outcome bit into the quotient.
module div_step #(
  parameter int WID = 32
) (
  input  logic [WID-1:0] i_rem,
  input  logic [WID-1:0] i_quo,
  input  logic [WID-1:0] i_dvs,
  output logic [WID-1:0] o_rem,
  output logic [WID-1:0] o_quo
);

  logic [WID:0]   w_shift;
  logic [WID+1:0] w_trial;
  logic           w_ge;

  // Partial remainder is always below the divisor, so the shifted value
  // fits WID+1 bits; one extra bit on the trial carries its sign.
  always_comb begin
    w_shift = {i_rem, i_quo[WID-1]};
    w_trial = {1'b0, w_shift} - {2'b00, i_dvs};
    w_ge    = ~w_trial[WID+1];
    o_rem   = w_ge ? w_trial[WID-1:0] : w_shift[WID-1:0];
    o_quo   = {i_quo[WID-2:0], w_ge};
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV.W/MOD.W/DIV.WU/MOD.WU sequencer for the Execute stage.
// Takes one request, runs WID restoring steps on magnitudes, applies the
// sign fix and holds the result until Execute consumes it.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int WID = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  input  logic [DIV_OP_WID-1:0] req_op,
  input  logic [WID-1:0]        src1,
  input  logic [WID-1:0]        src2,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WID-1:0]        result,
  output logic                  busy
);

  localparam int CW = (WID > 1) ? $clog2(WID) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WID - 1);

  div_state_e     r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [WID-1:0] r_a, r_b, r_rem, r_quo, r_result;
  div_op_t        r_op;
  logic           r_q_neg, r_r_neg;
  logic           w_accept;
  logic [WID-1:0] w_abs_a, w_abs_b, w_rem_n, w_quo_n;

  div_step #(.WID(WID)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_b),
    .o_rem (w_rem_n),
    .o_quo (w_quo_n)
  );

  assign w_abs_a = (r_op.is_signed && r_a[WID-1]) ? -r_a : r_a;
  assign w_abs_b = (r_op.is_signed && r_b[WID-1]) ? -r_b : r_b;
  assign result  = r_result;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and handshake outputs; flush overrides every transition
  always_comb begin
    // NOTE: every output gets a default before the case so no path
    // leaves a signal unassigned and infers a latch.
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // Gated by rstn so nothing is offered while reset is held.
        req_ready = rstn & ~flush;
        if (req_valid && req_ready) begin
          w_accept = 1'b1;
          w_next   = S_PREP;
        end
      end
      S_PREP:  w_next = (r_b == '0) ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == LAST_STEP) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Datapath: operand capture, magnitude prep, iteration and sign fix
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: datapath registers are reset too so result reads 0 out of
    // reset and no stale operand survives an abort by reset.
    if (!rstn) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a  <= src1;
            r_b  <= src2;
            r_op <= decode_op(req_op);
          end
        end
        S_PREP: begin
          if (r_b == '0) begin
            // Divide by zero: all-ones quotient, original dividend as remainder.
            r_result <= r_op.is_div ? '1 : r_a;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_b     <= w_abs_b;
            r_cnt   <= '0;
            r_q_neg <= r_op.is_signed & (r_a[WID-1] ^ r_b[WID-1]);
            r_r_neg <= r_op.is_signed & r_a[WID-1];
          end
        end
        S_CALC: begin
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          // INT_MIN/-1 falls out naturally: magnitude 2^(WID-1), no negation.
          if (r_op.is_div) r_result <= r_q_neg ? -r_quo : r_quo;
          else             r_result <= r_r_neg ? -r_rem : r_rem;
        end
        default: ;
      endcase
    end
  end

endmodule
